// File: rtl/model_scalar_integer_multiplier_arbiter_if.sv
// Purpose: bundles the client request/response bus and the shared-multiplier bus of the arbiter.
// Latency: none (wiring only).
// Backpressure: clients see BUSY per slot; a START on a busy slot is dropped by the arbiter.
//
// Ports (slave = arbiter view):
//   START/DATA_A_IN/DATA_B_IN   client requests, client i at [i*DATA_SIZE +: DATA_SIZE]
//   BUSY/READY/DATA_OUT/OVERFLOW_OUT/ERROR_OUT   per-client status and shared result
//   MUL_START/MUL_DATA_A/MUL_DATA_B              request to the shared multiplier
//   MUL_READY/MUL_DATA_OUT/MUL_OVERFLOW          response from the shared multiplier
interface model_scalar_integer_multiplier_arbiter_if #(
    parameter int DATA_SIZE  = 64,
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0]           START;
    logic [REQUESTERS*DATA_SIZE-1:0] DATA_A_IN;
    logic [REQUESTERS*DATA_SIZE-1:0] DATA_B_IN;
    logic [REQUESTERS-1:0]           BUSY;
    logic [REQUESTERS-1:0]           READY;
    logic [DATA_SIZE-1:0]            DATA_OUT;
    logic                            OVERFLOW_OUT;
    logic                            ERROR_OUT;
    logic                            MUL_START;
    logic [DATA_SIZE-1:0]            MUL_DATA_A;
    logic [DATA_SIZE-1:0]            MUL_DATA_B;
    logic                            MUL_READY;
    logic [DATA_SIZE-1:0]            MUL_DATA_OUT;
    logic                            MUL_OVERFLOW;

    modport master (
        output START, DATA_A_IN, DATA_B_IN, MUL_READY, MUL_DATA_OUT, MUL_OVERFLOW,
        input  BUSY, READY, DATA_OUT, OVERFLOW_OUT, ERROR_OUT,
               MUL_START, MUL_DATA_A, MUL_DATA_B
    );

    modport slave (
        input  START, DATA_A_IN, DATA_B_IN, MUL_READY, MUL_DATA_OUT, MUL_OVERFLOW,
        output BUSY, READY, DATA_OUT, OVERFLOW_OUT, ERROR_OUT,
               MUL_START, MUL_DATA_A, MUL_DATA_B
    );
endinterface

// File: rtl/model_scalar_integer_multiplier_arbiter.sv
// Purpose: round-robin sharing of one scalar multiplier between REQUESTERS clients, with watchdog.
// Latency: START in cycle 0 -> MUL_START cycle 2 -> READY cycle 5 with a 2-cycle multiplier.
// Backpressure: one buffered request per client; START while BUSY is dropped.
//
// Ports: CLK (rising edge), RST (async active-low), bus (slave modport of the arbiter interface).
module model_scalar_integer_multiplier_arbiter #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int REQUESTERS   = 4,
    parameter int TIMEOUT      = 16
) (
    input logic CLK,
    input logic RST,
    model_scalar_integer_multiplier_arbiter_if.slave bus
);
    localparam int GW = $clog2(REQUESTERS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

    state_t                  state_q, state_d;
    logic [REQUESTERS-1:0]   pending_q, pending_d;
    logic [DATA_SIZE-1:0]    buf_a_q [REQUESTERS];
    logic [DATA_SIZE-1:0]    buf_a_d [REQUESTERS];
    logic [DATA_SIZE-1:0]    buf_b_q [REQUESTERS];
    logic [DATA_SIZE-1:0]    buf_b_d [REQUESTERS];
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [DATA_SIZE-1:0]    mul_a_q, mul_a_d;
    logic [DATA_SIZE-1:0]    mul_b_q, mul_b_d;
    logic [CONTROL_SIZE-1:0] wd_cnt_q, wd_cnt_d;
    logic [DATA_SIZE-1:0]    result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;

    logic                    pick_vld;
    logic [GW-1:0]           pick_idx;

    // Round-robin pick: first pending slot strictly after last_grant, wrapping.
    // k runs to REQUESTERS so last_grant itself is the lowest-priority candidate.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            if (!pick_vld && pending_q[(int'(last_grant_q) + k) % REQUESTERS]) begin
                pick_vld = 1'b1;
                pick_idx = GW'((int'(last_grant_q) + k) % REQUESTERS);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        buf_a_d      = buf_a_q;
        buf_b_d      = buf_b_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        wd_cnt_d     = wd_cnt_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        err_d        = err_q;

        // Capture only into free slots; the granted slot stays pending through
        // RESPOND, so a START there cannot collide with the clear below.
        for (int i = 0; i < REQUESTERS; i++) begin
            if (bus.START[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                buf_a_d[i]   = bus.DATA_A_IN[i*DATA_SIZE +: DATA_SIZE];
                buf_b_d[i]   = bus.DATA_B_IN[i*DATA_SIZE +: DATA_SIZE];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    mul_a_d = buf_a_q[pick_idx];
                    mul_b_d = buf_b_q[pick_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.MUL_READY) begin
                    result_d = bus.MUL_DATA_OUT;
                    ovf_d    = bus.MUL_OVERFLOW;
                    err_d    = 1'b0;
                    state_d  = S_RESPOND;
                end else if (wd_cnt_q == CONTROL_SIZE'(TIMEOUT - 1)) begin
                    // Multiplier never answered: report a zero product flagged as error.
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_RESPOND;
                end else begin
                    wd_cnt_d = wd_cnt_q + CONTROL_SIZE'(1);
                end
            end
            S_RESPOND: begin
                pending_d[grant_q] = 1'b0;
                last_grant_d       = grant_q;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            for (int i = 0; i < REQUESTERS; i++) begin
                buf_a_q[i] <= '0;
                buf_b_q[i] <= '0;
            end
            grant_q      <= '0;
            last_grant_q <= GW'(REQUESTERS - 1);
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            wd_cnt_q     <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            buf_a_q      <= buf_a_d;
            buf_b_q      <= buf_b_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            wd_cnt_q     <= wd_cnt_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
        end
    end

    assign bus.BUSY         = pending_q;
    assign bus.READY        = (state_q == S_RESPOND) ? (REQUESTERS'(1) << grant_q) : '0;
    assign bus.DATA_OUT     = result_q;
    assign bus.OVERFLOW_OUT = ovf_q;
    assign bus.ERROR_OUT    = err_q;
    assign bus.MUL_START    = (state_q == S_ISSUE);
    assign bus.MUL_DATA_A   = mul_a_q;
    assign bus.MUL_DATA_B   = mul_b_q;
endmodule

// File: tb/tb_model_scalar_integer_multiplier_arbiter.sv
// Purpose: self-checking bench for the multiplier arbiter with a 2-cycle multiplier model.
// Latency: n/a.
// Backpressure: n/a.
module tb_model_scalar_integer_multiplier_arbiter;
    localparam int DW = 64;
    localparam int NR = 4;

    logic clk;
    logic rst_n;

    model_scalar_integer_multiplier_arbiter_if #(.DATA_SIZE(DW), .REQUESTERS(NR)) bus ();

    model_scalar_integer_multiplier_arbiter #(
        .DATA_SIZE(DW), .CONTROL_SIZE(64), .REQUESTERS(NR), .TIMEOUT(16)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: samples MUL_START at edge N, answers in cycle N+2.
    logic          mul_dead = 1'b0;
    logic          mul_s1;
    logic [DW-1:0] mul_a_s1, mul_b_s1;
    logic [127:0]  mul_full;
    assign mul_full = {64'd0, mul_a_s1} * {64'd0, mul_b_s1};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_s1           <= 1'b0;
            mul_a_s1         <= '0;
            mul_b_s1         <= '0;
            bus.MUL_READY    <= 1'b0;
            bus.MUL_DATA_OUT <= '0;
            bus.MUL_OVERFLOW <= 1'b0;
        end else begin
            mul_s1           <= bus.MUL_START && !mul_dead;
            mul_a_s1         <= bus.MUL_DATA_A;
            mul_b_s1         <= bus.MUL_DATA_B;
            bus.MUL_READY    <= mul_s1;
            bus.MUL_DATA_OUT <= mul_full[63:0];
            bus.MUL_OVERFLOW <= |mul_full[127:64];
        end
    end

    typedef struct {
        int            client;
        logic [DW-1:0] data;
        logic          ovf;
        logic          err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            client;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp_p;
        logic          exp_ovf;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.START[c]              = 1'b1;
        bus.DATA_A_IN[c*DW +: DW] = a;
        bus.DATA_B_IN[c*DW +: DW] = b;
    endtask

    task automatic push(input int c, input logic [DW-1:0] d, input logic o, input logic e);
        exp_t x;
        x.client = c;
        x.data   = d;
        x.ovf    = o;
        x.err    = e;
        sb.push_back(x);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while ((sb.size() != 0 || bus.BUSY != '0) && n < max) begin
            step();
            n++;
        end
        chk(name, 64'(sb.size() == 0 && bus.BUSY == '0), 64'd1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.START = '0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every READY pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.READY != '0) begin
            int   cl;
            exp_t e;
            cl = -1;
            ready_cnt++;
            for (int i = 0; i < NR; i++) if (bus.READY[i]) cl = i;
            chk("ready_onehot", 64'($countones(bus.READY)), 64'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ready: actual READY=%b required no pulse (cycle %0d)", bus.READY, cyc);
            end else begin
                e = sb.pop_front();
                chk("sb_client", 64'(cl), 64'(e.client));
                chk("sb_data", bus.DATA_OUT, e.data);
                chk("sb_ovf", 64'(bus.OVERFLOW_OUT), 64'(e.ovf));
                chk("sb_err", 64'(bus.ERROR_OUT), 64'(e.err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int issue_c, rc, posted, n0, n2, rep, got, last_t, exp_k;
        logic found, chk_busy;
        logic [NR-1:0] exp_busy;

        vecs[0] = '{2, 64'd12345, 64'd1000, 64'd12345000, 1'b0};
        vecs[1] = '{0, 64'd0, 64'hDEAD, 64'd0, 1'b0};
        vecs[2] = '{3, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1};
        vecs[3] = '{1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
        vecs[4] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1};

        bus.START     = '0;
        bus.DATA_A_IN = '0;
        bus.DATA_B_IN = '0;
        do_reset();

        // Reset values
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_ready", 64'(bus.READY), 64'd0);
        chk("rst_data", bus.DATA_OUT, 64'd0);
        chk("rst_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);
        chk("rst_err", 64'(bus.ERROR_OUT), 64'd0);
        chk("rst_mul_start", 64'(bus.MUL_START), 64'd0);
        chk("rst_mul_a", bus.MUL_DATA_A, 64'd0);
        chk("rst_mul_b", bus.MUL_DATA_B, 64'd0);

        // Single request, cycle-exact latency (cycle 0 = START)
        post(1, 64'd7, 64'd6);
        push(1, 64'd42, 1'b0, 1'b0);
        step(); bus.START = '0;                                  // cycle 1
        chk("lat_busy_c1", 64'(bus.BUSY), 64'b0010);
        chk("lat_nostart_c1", 64'(bus.MUL_START), 64'd0);
        step();                                                  // cycle 2
        chk("lat_mul_start_c2", 64'(bus.MUL_START), 64'd1);
        chk("lat_mul_a_c2", bus.MUL_DATA_A, 64'd7);
        chk("lat_mul_b_c2", bus.MUL_DATA_B, 64'd6);
        step();                                                  // cycle 3
        chk("lat_mul_start_c3", 64'(bus.MUL_START), 64'd0);
        chk("lat_mul_a_c3", bus.MUL_DATA_A, 64'd7);
        step();                                                  // cycle 4
        chk("lat_noready_c4", 64'(bus.READY), 64'd0);
        step();                                                  // cycle 5
        chk("lat_ready_c5", 64'(bus.READY), 64'b0010);
        chk("lat_data_c5", bus.DATA_OUT, 64'd42);
        step();                                                  // cycle 6
        chk("lat_busy_c6", 64'(bus.BUSY), 64'd0);
        chk("lat_data_hold", bus.DATA_OUT, 64'd42);

        // Table of single requests across clients and overflow boundaries
        for (int v = 0; v < 6; v++) begin
            post(vecs[v].client, vecs[v].a, vecs[v].b);
            push(vecs[v].client, vecs[v].exp_p, vecs[v].exp_ovf, 1'b0);
            step(); bus.START = '0;
            wait_idle($sformatf("vec%0d_done", v), 40);
        end

        // Watchdog: dead multiplier
        mul_dead = 1'b1;
        post(0, 64'd5, 64'd6);
        push(0, 64'd0, 1'b0, 1'b1);
        step(); bus.START = '0;
        found = 1'b0; issue_c = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (bus.MUL_START) begin found = 1'b1; issue_c = cyc; end
            else step();
        end
        chk("wd_issue_seen", 64'(found), 64'd1);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (bus.READY != '0) begin
                found = 1'b1;
                chk("wd_latency", 64'(cyc - issue_c), 64'd17);
            end
        end
        chk("wd_ready_seen", 64'(found), 64'd1);
        mul_dead = 1'b0;
        wait_idle("wd_done", 10);
        chk("wd_err_hold", 64'(bus.ERROR_OUT), 64'd1);
        post(1, 64'd5, 64'd5);
        push(1, 64'd25, 1'b0, 1'b0);
        step(); bus.START = '0;
        wait_idle("wd_recover_done", 40);

        // Simultaneous STARTs after reset
        do_reset();
        for (int i = 0; i < NR; i++) begin
            post(i, 64'(i + 1), 64'd10);
            push(i, 64'((i + 1) * 10), 1'b0, 1'b0);
        end
        step(); bus.START = '0;
        chk("sim_busy_all", 64'(bus.BUSY), 64'b1111);
        got = 0; last_t = 0; chk_busy = 1'b0; exp_busy = '0;
        for (int c = 0; c < 80 && (got < NR || chk_busy); c++) begin
            step();
            if (chk_busy) begin
                chk("sim_busy_drop", 64'(bus.BUSY), 64'(exp_busy));
                chk_busy = 1'b0;
            end
            if (bus.READY != '0) begin
                if (got > 0) chk("sim_spacing", 64'(cyc - last_t), 64'd5);
                last_t   = cyc;
                got++;
                exp_busy = 4'b1111 << got;
                chk_busy = 1'b1;
            end
        end
        chk("sim_all_served", 64'(got), 64'(NR));
        wait_idle("sim_done", 10);

        // Fairness: clients 0 and 2 re-post after each completion
        post(0, 64'd1, 64'd1); push(0, 64'd1, 1'b0, 1'b0);
        post(2, 64'd3, 64'd2); push(2, 64'd6, 1'b0, 1'b0);
        posted = 2; n0 = 0; n2 = 0; rep = -1; exp_k = 0;
        for (int c = 0; c < 200 && (n0 + n2) < 6; c++) begin
            step();
            bus.START = '0;
            if (rep >= 0) begin
                post(rep, 64'(rep + 1), 64'(posted + 1));
                push(rep, 64'((rep + 1) * (posted + 1)), 1'b0, 1'b0);
                posted++;
                rep = -1;
            end
            if (bus.READY != '0) begin
                chk("fair_alternate", 64'(bus.READY), 64'(1 << exp_k));
                exp_k = (exp_k == 0) ? 2 : 0;
                if (bus.READY[0]) begin n0++; if (posted < 6) rep = 0; end
                if (bus.READY[2]) begin n2++; if (posted < 6) rep = 2; end
            end
        end
        bus.START = '0;
        chk("fair_n0", 64'(n0), 64'd3);
        chk("fair_n2", 64'(n2), 64'd3);
        wait_idle("fair_done", 20);

        // Ignored re-START while busy
        rc = ready_cnt;
        post(3, 64'd3, 64'd3);
        push(3, 64'd9, 1'b0, 1'b0);
        step(); bus.START = '0;
        chk("restart_busy", 64'(bus.BUSY[3]), 64'd1);
        post(3, 64'd9, 64'd9);
        step(); bus.START = '0;
        wait_idle("restart_done", 40);
        repeat (10) step();
        chk("restart_one_resp", 64'(ready_cnt - rc), 64'd1);
        chk("restart_data", bus.DATA_OUT, 64'd9);

        // Reset mid-WAIT with two pending requests
        post(1, 64'd11, 64'd3);
        post(2, 64'd4, 64'd4);
        step(); bus.START = '0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (bus.MUL_START) found = 1'b1;
            else step();
        end
        chk("rstw_issue_seen", 64'(found), 64'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", 64'(bus.BUSY), 64'd0);
        chk("rstw_ready", 64'(bus.READY), 64'd0);
        chk("rstw_data", bus.DATA_OUT, 64'd0);
        chk("rstw_mul_start", 64'(bus.MUL_START), 64'd0);
        chk("rstw_mul_a", bus.MUL_DATA_A, 64'd0);
        chk("rstw_mul_b", bus.MUL_DATA_B, 64'd0);
        sb.delete();
        rc = ready_cnt;
        step(); step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("rstw_no_ready", 64'(ready_cnt - rc), 64'd0);
        post(0, 64'd2, 64'd3); push(0, 64'd6, 1'b0, 1'b0);
        post(3, 64'd4, 64'd4); push(3, 64'd16, 1'b0, 1'b0);
        step(); bus.START = '0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (bus.READY != '0) begin
                found = 1'b1;
                chk("rstw_first_grant", 64'(bus.READY), 64'b0001);
            end
        end
        chk("rstw_ready_seen", 64'(found), 64'd1);
        wait_idle("rstw_done", 40);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/model_scalar_integer_multiplier_arbiter.md
# model_scalar_integer_multiplier_arbiter

Round-robin arbiter and sequencer that shares one scalar integer multiplier between REQUESTERS clients. Each client posts a START pulse with its operands. The block buffers the operands, grants the multiplier to one pending client at a time, and returns the product with a per-client READY pulse. A watchdog recovers from a multiplier that never answers. It sits between the NTM vector/matrix controllers and the single shared multiplier instance.

## Interface
- DATA_SIZE, 64, operand/result width
- CONTROL_SIZE, 64, width of internal counters
- REQUESTERS, 4, number of clients (2..16)
- TIMEOUT, 16, maximum WAIT cycles before the watchdog fires (≥4)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  REQUESTERS  per-client request pulse
- DATA_A_IN  in  REQUESTERS*DATA_SIZE  client i operand A at [i*DATA_SIZE +: DATA_SIZE]
- DATA_B_IN  in  REQUESTERS*DATA_SIZE  client i operand B, same slicing
- BUSY  out  REQUESTERS  client i has a pending or in-flight request
- READY  out  REQUESTERS  one-cycle completion pulse, one-hot or zero
- DATA_OUT  out  DATA_SIZE  product for the client pulsing READY
- OVERFLOW_OUT  out  1  overflow from the multiplier, qualified by READY
- ERROR_OUT  out  1  watchdog fired, qualified by READY
- MUL_START  out  1  multiplier start pulse
- MUL_DATA_A, MUL_DATA_B  out  DATA_SIZE  multiplier operands
- MUL_READY  in  1  multiplier completion pulse
- MUL_DATA_OUT  in  DATA_SIZE  multiplier product
- MUL_OVERFLOW  in  1  multiplier overflow

## Operation
- Per-client buffer: a pending bit plus A/B registers. When START[i]=1 and pending[i]=0, the block captures the operands and sets pending[i] at that edge.
- START[i] while pending[i]=1 is ignored; the buffered operands are unchanged.
- BUSY = pending, registered.
- States: IDLE, ISSUE, WAIT, RESPOND. Reset state is IDLE.
- IDLE:
  - If any pending bit is set, pick the first set index searching upward from last_grant+1, wrapping modulo REQUESTERS.
  - Register grant; drive MUL_DATA_A/B from that client's buffer; go to ISSUE.
  - With no pending bit set, stay in IDLE.
- ISSUE:
  - MUL_START=1 for exactly this cycle, with operands stable.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - MUL_START=0 and MUL_DATA_A/B held for the whole state.
  - On MUL_READY=1, latch MUL_DATA_OUT and MUL_OVERFLOW, clear the error flag, and go to RESPOND.
  - Otherwise increment the counter. When it reaches TIMEOUT-1, set error=1, set result to 0 and overflow to 0, and go to RESPOND.
- RESPOND:
  - READY[grant]=1; DATA_OUT, OVERFLOW_OUT and ERROR_OUT are driven from the latched values.
  - Clear pending[grant], set last_grant=grant, go to IDLE.
- A START[grant] in the RESPOND cycle is not accepted, because pending is still 1. It is accepted from the following cycle.
- A MUL_READY outside WAIT is ignored.
- Arithmetic is done entirely by the multiplier; the block never modifies the product.

## Timing
- Reset values:
  - BUSY=0, READY=0, DATA_OUT=0, OVERFLOW_OUT=0, ERROR_OUT=0.
  - MUL_START=0, MUL_DATA_A/B=0.
  - All pending bits=0, last_grant=REQUESTERS-1, so client 0 wins first.
- Reset asserted mid-operation: everything returns to reset values asynchronously, and in-flight and pending requests are discarded.
- Multiplier contract: it samples MUL_START at edge N and pulses MUL_READY in cycle N+2, with MUL_DATA_OUT valid in that cycle.
- Latency for an idle arbiter:
  - START[i] high in cycle 0; BUSY[i] high from cycle 1.
  - ISSUE (MUL_START) in cycle 2; MUL_READY in cycle 4.
  - READY[i] and DATA_OUT in cycle 5; BUSY[i] low from cycle 6.
- Throughput: one grant every 5 cycles with a prompt multiplier, counted ISSUE to ISSUE.
- DATA_OUT, OVERFLOW_OUT and ERROR_OUT hold their last values between READY pulses.
- Watchdog timing: ISSUE in cycle c with no MUL_READY gives READY in cycle c+TIMEOUT+1, with ERROR_OUT=1 and DATA_OUT=0.
- Simultaneous STARTs: all are buffered in the same cycle, and service follows round-robin order.

## Test plan
- Single request: client 1, A=7, B=6 → READY=0b0010 in cycle 5, DATA_OUT=42, OVERFLOW_OUT=0, ERROR_OUT=0; MUL_START high for exactly one cycle.
- Simultaneous STARTs after reset: all four clients, A=i+1, B=10 → READY order 0,1,2,3, products 10,20,30,40, 5 cycles apart; BUSY bits drop in the same order.
- Fairness: clients 0 and 2 re-post START on every completion → grants alternate 0,2,0,2; neither client is starved.
- Ignored re-START: client 3 posts A=3,B=3, then A=9,B=9 while BUSY[3]=1 → the single response is 9 and the second START is dropped.
- Watchdog: MUL_READY held at 0 with TIMEOUT=16 → READY in cycle ISSUE+17 with ERROR_OUT=1, DATA_OUT=0; the next request then completes normally.
- Reset mid-WAIT: drive RST=0 while in WAIT with two requests pending → all outputs are 0 immediately and no READY pulse ever appears; a fresh request after RST=1 is served with grant to client 0.
